// File: rtl/term_ctrl.sv
// Serial-terminal controller: turns received bytes into VRAM port-A writes, tracks the
// cursor and attribute, and runs control codes, scrolling, screen clear and the visual bel.
module term_ctrl #(
  parameter int         COLS       = 64,
  parameter int         ROWS       = 32,
  parameter int         BEL_CYCLES = 1200000,
  parameter logic [7:0] BLANK      = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [10:0] o_vram_addr,
  output logic [8:0]  o_vram_din,
  input  logic [8:0]  i_vram_dout,
  output logic        o_vram_ce,
  output logic        o_vram_wre,
  output logic        o_bel,
  output logic        o_busy
);

  localparam int         BW         = (BEL_CYCLES > 1) ? $clog2(BEL_CYCLES) : 1;
  localparam logic [5:0] X_LAST     = 6'(COLS - 1);
  localparam logic [4:0] Y_LAST     = 5'(ROWS - 1);
  localparam logic [4:0] Y_PENULT   = 5'(ROWS - 2);
  localparam logic [8:0] BLANK_CELL = {1'b0, BLANK};

  typedef enum logic [2:0] {
    ST_RESET,
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_CTRL,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_FILL
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      cx_q, cx_d;
  logic [4:0]      cy_q, cy_d;
  logic [5:0]      col_q, col_d;
  logic [4:0]      row_q, row_d;
  logic            attr_q, attr_d;
  logic [7:0]      char_q, char_d;
  logic            bel_q, bel_d;
  logic [BW-1:0]   bel_cnt_q, bel_cnt_d;
  logic            accept;
  logic [4:0]      row_below;

  assign accept     = i_rx_valid && (state_q == ST_IDLE);
  assign row_below  = row_q + 5'd1;
  assign o_rx_ready = (state_q == ST_IDLE);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_bel      = bel_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_RESET;
      cx_q      <= '0;
      cy_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      attr_q    <= 1'b0;
      char_q    <= '0;
      bel_q     <= 1'b0;
      bel_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      col_q     <= col_d;
      row_q     <= row_d;
      attr_q    <= attr_d;
      char_q    <= char_d;
      bel_q     <= bel_d;
      bel_cnt_q <= bel_cnt_d;
    end
  end

  // Bel timer runs independently of the main FSM; a retrigger simply reloads it.
  always_comb begin
    bel_d     = bel_q;
    bel_cnt_d = bel_cnt_q;
    if (accept && (i_rx_data == 8'h07)) begin
      bel_d     = 1'b1;
      bel_cnt_d = BW'(BEL_CYCLES - 1);
    end else if (bel_q) begin
      if (bel_cnt_q == '0) begin
        bel_d = 1'b0;
      end else begin
        bel_cnt_d = bel_cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    col_d       = col_q;
    row_d       = row_q;
    attr_d      = attr_q;
    char_d      = char_q;
    o_vram_ce   = 1'b0;
    o_vram_wre  = 1'b0;
    o_vram_addr = {cy_q, cx_q};
    o_vram_din  = {attr_q, char_q};

    case (state_q)
      ST_RESET: begin
        col_d   = '0;
        row_d   = '0;
        state_d = ST_CLEAR;
      end

      ST_CLEAR: begin
        o_vram_ce   = 1'b1;
        o_vram_wre  = 1'b1;
        o_vram_addr = {row_q, col_q};
        o_vram_din  = BLANK_CELL;
        if (col_q == X_LAST) begin
          col_d = '0;
          if (row_q == Y_LAST) begin
            row_d   = '0;
            cx_d    = '0;
            cy_d    = '0;
            state_d = ST_IDLE;
          end else begin
            row_d = row_below;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          char_d = i_rx_data;
          if ((i_rx_data >= 8'h20) && (i_rx_data <= 8'h7E)) begin
            state_d = ST_WRITE;
          end else begin
            case (i_rx_data)
              8'h0D: begin
                cx_d    = '0;
                state_d = ST_CTRL;
              end
              8'h08: begin
                if (cx_q != '0) cx_d = cx_q - 6'd1;
                state_d = ST_CTRL;
              end
              8'h0E: begin
                attr_d  = 1'b1;
                state_d = ST_CTRL;
              end
              8'h0F: begin
                attr_d  = 1'b0;
                state_d = ST_CTRL;
              end
              8'h07: state_d = ST_CTRL;
              8'h0A: begin
                if (cy_q != Y_LAST) begin
                  cy_d = cy_q + 5'd1;
                end else begin
                  row_d   = '0;
                  col_d   = '0;
                  state_d = ST_SCR_RD;
                end
              end
              8'h0C: begin
                row_d   = '0;
                col_d   = '0;
                state_d = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end

      ST_WRITE: begin
        o_vram_ce  = 1'b1;
        o_vram_wre = 1'b1;
        state_d    = ST_IDLE;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q != Y_LAST) begin
            cy_d = cy_q + 5'd1;
          end else begin
            row_d   = '0;
            col_d   = '0;
            state_d = ST_SCR_RD;
          end
        end else begin
          cx_d = cx_q + 6'd1;
        end
      end

      ST_CTRL: state_d = ST_IDLE;

      // Each cell is moved up one row with a read followed by a write of the returned data.
      ST_SCR_RD: begin
        o_vram_ce   = 1'b1;
        o_vram_addr = {row_below, col_q};
        state_d     = ST_SCR_WR;
      end

      ST_SCR_WR: begin
        o_vram_ce   = 1'b1;
        o_vram_wre  = 1'b1;
        o_vram_addr = {row_q, col_q};
        o_vram_din  = i_vram_dout;
        state_d     = ST_SCR_RD;
        if (col_q == X_LAST) begin
          col_d = '0;
          if (row_q == Y_PENULT) begin
            state_d = ST_FILL;
          end else begin
            row_d = row_below;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end

      ST_FILL: begin
        o_vram_ce   = 1'b1;
        o_vram_wre  = 1'b1;
        o_vram_addr = {Y_LAST, col_q};
        o_vram_din  = BLANK_CELL;
        if (col_q == X_LAST) begin
          col_d   = '0;
          row_d   = '0;
          state_d = ST_IDLE;
        end else begin
          col_d = col_q + 6'd1;
        end
      end

      default: state_d = ST_RESET;
    endcase
  end

endmodule
